// File: rtl/des_pkg.sv
// des_pkg: shared DES widths and round-engine FSM encoding
package des_pkg;
    localparam int DES_BLOCK_W    = 64;
    localparam int DES_HALF_W     = 32;
    localparam int DES_KEY_W      = 48;
    localparam int DES_MAX_ROUNDS = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/feistel_function.sv
// Feistel_Function: combinational DES f(R,K) = P(S(E(R) ^ K))
module Feistel_Function
    import des_pkg::*;
(
    input  logic [DES_HALF_W-1:0] R_in,
    input  logic [DES_KEY_W-1:0]  subkey,
    output logic [DES_HALF_W-1:0] f_out
);
    // Each S-box is 64 nibbles, entry {b1,b6,b2..b5} stored MSB-first
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };
    localparam int PERM [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                                 1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};
    logic [DES_KEY_W-1:0]  x;
    logic [DES_HALF_W-1:0] s;
    logic [5:0]            six;
    always_comb begin
        x     = '0;
        s     = '0;
        six   = '0;
        f_out = '0;
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 6; j++)
                x[47-6*g-j] = R_in[31-((4*g+j+31)%32)];
        x = x ^ subkey;
        for (int g = 0; g < 8; g++) begin
            six = x[47-6*g -: 6];
            s[31-4*g -: 4] = SBOX[g][255-4*int'({six[5], six[0], six[4:1]}) -: 4];
        end
        for (int i = 0; i < 32; i++)
            f_out[31-i] = s[31-PERM[i]];
    end
endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel rounds on a pre-IP block, subkeys fetched by index
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int PIPE_F = 0,
    parameter int IDX_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DES_BLOCK_W-1:0] in_data,
    input  logic                   in_decrypt,
    output logic [IDX_W-1:0]       key_idx,
    input  logic [DES_KEY_W-1:0]   subkey,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DES_BLOCK_W-1:0] out_data
);
    state_t                state, state_d;
    logic [DES_HALF_W-1:0] l, r, f_out, f_use;
    logic [IDX_W:0]        rnd;
    logic                  dec, phase, step, last;

    Feistel_Function u_f (.R_in(r), .subkey(subkey), .f_out(f_out));

    assign step = state == RUN && (PIPE_F == 0 || phase);
    assign last = rnd == (IDX_W+1)'(ROUNDS - 1);

    always_comb begin
        state_d   = (state == IDLE && in_valid)  ? RUN  :
                    (step && last)               ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        key_idx   = state == IDLE ? '0 :
                    dec ? IDX_W'(ROUNDS - 1) - rnd[IDX_W-1:0] : rnd[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            l        <= '0;
            r        <= '0;
            dec      <= 1'b0;
            rnd      <= '0;
            phase    <= 1'b0;
            out_data <= '0;
        end else if (state == IDLE && in_valid) begin
            l     <= in_data[63:32];
            r     <= in_data[31:0];
            dec   <= in_decrypt;
            rnd   <= '0;
            phase <= 1'b0;
        end else if (state == RUN) begin
            if (PIPE_F != 0) phase <= ~phase;
            if (step) begin
                l   <= r;
                r   <= l ^ f_use;
                rnd <= rnd + (IDX_W+1)'(1);
                if (last) out_data <= {l ^ f_use, r};
            end
        end

    // Pipelined variant: phase 0 captures f(), phase 1 consumes it with the same key_idx
    if (PIPE_F != 0) begin : g_pipe
        logic [DES_HALF_W-1:0] f_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)                      f_q <= '0;
            else if (state == RUN && !phase) f_q <= f_out;
        assign f_use = f_q;
    end else begin : g_comb
        assign f_use = f_out;
    end
endmodule
